// File: rtl/transport_pkg.sv
// Shared types and constants for the in-to-out transport block mover.
package transport_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } xfer_state_t;

  localparam int RS_N = 204;
  localparam int RS_K = 188;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/transport_valid_delay.sv
// Valid-tag delay line matching the input memory read latency.
module transport_valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic out_valid
);

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = in_valid;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_valid = stage_q[DEPTH-1];

endmodule

// File: rtl/transport_pingpong_mover.sv
// Moves one COUNT-word block between ping-pong banks, one word per clock.
module transport_pingpong_mover
  import transport_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int COUNT    = RS_K,
  parameter int RD_START = RS_N,
  parameter int WR_START = 0,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dir,
  output logic              rd_bank,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_bank,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] RD_BASE = ADDR_W'(RD_START);
  localparam logic [ADDR_W-1:0] WR_BASE = ADDR_W'(WR_START);

  xfer_state_t       state_q, state_d;
  logic              rd_bank_q, rd_bank_d;
  logic              wr_bank_q, wr_bank_d;
  logic              dir_q, dir_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic              tag_out;

  transport_valid_delay #(
    .DEPTH(RD_LAT)
  ) u_valid_delay (
    .clk      (clk),
    .reset    (reset),
    .in_valid (rd_en_q),
    .out_valid(tag_out)
  );

  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    wr_bank_d = wr_bank_q;
    dir_d     = dir_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_cnt_d  = rd_cnt_q;
    wr_en_d   = tag_out;
    wr_addr_d = wr_addr_q;
    wr_data_d = tag_out ? rd_data : wr_data_q;
    wr_cnt_d  = wr_cnt_q;
    done_d    = 1'b0;
    overrun_d = start && (state_q != IDLE);
    // write side advances after each presented write
    if (wr_en_q) begin
      wr_addr_d = wr_addr_q + A_ONE;
      wr_cnt_d  = wr_cnt_q + C_ONE;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = READ;
          rd_bank_d = ~rd_bank_q;
          wr_bank_d = ~wr_bank_q;
          dir_d     = dir;
          rd_en_d   = 1'b1;
          rd_addr_d = RD_BASE;
          rd_cnt_d  = '0;
          wr_addr_d = WR_BASE;
          wr_cnt_d  = '0;
        end
      end
      READ: begin
        if (rd_cnt_q == LAST) begin
          state_d = DRAIN;
        end else begin
          rd_en_d  = 1'b1;
          rd_cnt_d = rd_cnt_q + C_ONE;
          rd_addr_d = (dir_q == DIR_UP) ? rd_addr_q + A_ONE
                                        : rd_addr_q - A_ONE;
        end
      end
      DRAIN: begin
        if (wr_en_q && (wr_cnt_q == LAST)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_bank_q <= 1'b0;
      wr_bank_q <= 1'b0;
      dir_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_cnt_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_cnt_q  <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      wr_bank_q <= wr_bank_d;
      dir_q     <= dir_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_cnt_q  <= wr_cnt_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign rd_bank = rd_bank_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_bank = wr_bank_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_transport_pingpong_mover.sv
// Bench for transport_pingpong_mover: three parameterisations, memory word a = a.
module tb_transport_pingpong_mover;

  typedef struct {
    int         u;
    logic       d;
    int         cnt;
    int         lat;
    logic [7:0] rs;
    logic       bank;
    int         done_off;
    int         ovr_at;
    int         rst_at;
    logic       chain;
  } blk_t;

  logic       clk = 1'b0;
  logic [2:0] reset_v;
  logic [2:0] start_v;
  logic [2:0] dir_v;
  wire  [2:0] rd_bank_v, rd_en_v, wr_bank_v, wr_en_v;
  wire  [2:0] busy_v, done_v, overrun_v;
  wire  [7:0] rd_addr_v [3];
  wire  [7:0] wr_addr_v [3];
  wire  [7:0] wr_data_v [3];
  wire  [7:0] rd_data_v [3];
  logic [7:0] pipe [3][4];
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int u = 0; u < 3; u++) begin
      pipe[u][0] <= rd_addr_v[u];
      for (int j = 1; j < 4; j++) pipe[u][j] <= pipe[u][j-1];
    end
  end

  assign rd_data_v[0] = pipe[0][0];
  assign rd_data_v[1] = pipe[1][0];
  assign rd_data_v[2] = pipe[2][2];

  transport_pingpong_mover u0 (
    .clk(clk), .reset(reset_v[0]), .start(start_v[0]), .dir(dir_v[0]),
    .rd_bank(rd_bank_v[0]), .rd_en(rd_en_v[0]), .rd_addr(rd_addr_v[0]),
    .rd_data(rd_data_v[0]), .wr_bank(wr_bank_v[0]), .wr_en(wr_en_v[0]),
    .wr_addr(wr_addr_v[0]), .wr_data(wr_data_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .overrun(overrun_v[0])
  );

  transport_pingpong_mover #(.COUNT(10), .RD_START(250)) u1 (
    .clk(clk), .reset(reset_v[1]), .start(start_v[1]), .dir(dir_v[1]),
    .rd_bank(rd_bank_v[1]), .rd_en(rd_en_v[1]), .rd_addr(rd_addr_v[1]),
    .rd_data(rd_data_v[1]), .wr_bank(wr_bank_v[1]), .wr_en(wr_en_v[1]),
    .wr_addr(wr_addr_v[1]), .wr_data(wr_data_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .overrun(overrun_v[1])
  );

  transport_pingpong_mover #(.RD_LAT(3)) u2 (
    .clk(clk), .reset(reset_v[2]), .start(start_v[2]), .dir(dir_v[2]),
    .rd_bank(rd_bank_v[2]), .rd_en(rd_en_v[2]), .rd_addr(rd_addr_v[2]),
    .rd_data(rd_data_v[2]), .wr_bank(wr_bank_v[2]), .wr_en(wr_en_v[2]),
    .wr_addr(wr_addr_v[2]), .wr_data(wr_data_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .overrun(overrun_v[2])
  );

  task automatic check(input string nm, input logic [30:0] got,
                       input logic [30:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Field order: bank,rd_en,rd_addr,bank,wr_en,wr_addr,wr_data,busy,done,overrun
  task automatic do_block(input blk_t b, input bit pre);
    logic [30:0] got, want;
    logic [7:0]  ea, ew, ed;
    logic        ere, ewe, eb, ebusy, edn, eov, rstd, mr, mw;
    int          i, last;
    if (!pre) begin
      @(negedge clk);
      start_v[b.u] = 1'b1;
      dir_v[b.u]   = b.d;
    end
    @(posedge clk);
    last = b.chain ? b.done_off : b.done_off + 1;
    for (int t = 1; t <= last; t++) begin
      @(negedge clk);
      start_v[b.u] = 1'b0;
      reset_v[b.u] = 1'b0;
      if (b.ovr_at != 0 && t == b.ovr_at) begin
        start_v[b.u] = 1'b1;
        dir_v[b.u]   = ~b.d;
      end
      if (b.rst_at != 0 && t == b.rst_at) reset_v[b.u] = 1'b1;
      if (b.chain && t == b.done_off) begin
        start_v[b.u] = 1'b1;
        dir_v[b.u]   = b.d;
      end
      rstd  = (b.rst_at != 0) && (t > b.rst_at);
      i     = t - 2 - b.lat;
      ere   = (t <= b.cnt);
      ea    = b.d ? b.rs + 8'(t - 1) : b.rs - 8'(t - 1);
      ewe   = (i >= 0) && (i < b.cnt);
      ew    = 8'(i);
      ed    = b.d ? b.rs + 8'(i) : b.rs - 8'(i);
      ebusy = (t <= 1 + b.cnt + b.lat);
      edn   = (t == b.done_off);
      eov   = (b.ovr_at != 0) && (t == b.ovr_at + 1);
      eb    = b.bank;
      if (rstd) begin
        {ere, ewe, ebusy, edn, eov, eb} = '0;
        {ea, ew, ed} = '0;
      end
      mr = rstd | ere;
      mw = rstd | ewe;
      want = {eb, ere, ere ? ea : 8'h00, eb, ewe,
              ewe ? ew : 8'h00, ewe ? ed : 8'h00, ebusy, edn, eov};
      got  = {rd_bank_v[b.u], rd_en_v[b.u],
              mr ? rd_addr_v[b.u] : 8'h00,
              wr_bank_v[b.u], wr_en_v[b.u],
              mw ? wr_addr_v[b.u] : 8'h00,
              mw ? wr_data_v[b.u] : 8'h00,
              busy_v[b.u], done_v[b.u], overrun_v[b.u]};
      check($sformatf("blk u%0d t%0d", b.u, t), got, want);
    end
  endtask

  blk_t tbl [4];

  initial begin
    tbl[0] = '{0, 1'b0, 188, 1, 8'd204, 1'b1, 191, 0, 0, 1'b0};
    tbl[1] = '{1, 1'b1, 10,  1, 8'd250, 1'b1, 13,  0, 0, 1'b0};
    tbl[2] = '{2, 1'b0, 188, 3, 8'd204, 1'b1, 193, 0, 0, 1'b0};
    tbl[3] = '{1, 1'b0, 10,  1, 8'd250, 1'b0, 13,  0, 0, 1'b0};

    reset_v = 3'b111;
    start_v = 3'b000;
    dir_v   = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check($sformatf("reset u%0d", u),
            {rd_bank_v[u], rd_en_v[u], rd_addr_v[u], wr_bank_v[u],
             wr_en_v[u], wr_addr_v[u], wr_data_v[u], busy_v[u],
             done_v[u], overrun_v[u]}, 31'h0);
    end
    reset_v = 3'b000;

    for (int n = 0; n < 4; n++) do_block(tbl[n], 1'b0);

    // overrun mid-block, then back-to-back blocks, then reset mid-block
    do_block('{0, 1'b0, 188, 1, 8'd204, 1'b0, 191, 50, 0, 1'b0}, 1'b0);
    do_block('{0, 1'b0, 188, 1, 8'd204, 1'b1, 191, 0, 0, 1'b1}, 1'b0);
    do_block('{0, 1'b0, 188, 1, 8'd204, 1'b0, 191, 0, 0, 1'b0}, 1'b1);
    do_block('{0, 1'b0, 188, 1, 8'd204, 1'b1, 191, 0, 100, 1'b0}, 1'b0);
    do_block('{0, 1'b1, 188, 1, 8'd204, 1'b1, 191, 0, 0, 1'b0}, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
